// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS-subset main control FSM:
// state encodings, supported opcodes, ALUop codes and the mux select
// constants for the ALU B operand and PC source.
package multicycle_control_pkg;

  // State encodings; stateDbg reports these values directly.
  typedef enum logic [3:0] {
    STATE_FETCH   = 4'd0,
    STATE_DECODE  = 4'd1,
    STATE_MEMADR  = 4'd2,
    STATE_MEMRD   = 4'd3,
    STATE_MEMWB   = 4'd4,
    STATE_MEMWR   = 4'd5,
    STATE_EXECUTE = 4'd6,
    STATE_ALUWB   = 4'd7,
    STATE_BRANCH  = 4'd8,
    STATE_JUMP    = 4'd9
  } state_e;

  // Supported opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUop codes handed to the ALU control unit.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand selects.
  localparam logic [1:0] ALUSRCB_B       = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  // PC source selects.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for the five opcodes this datapath implements.
  function automatic logic op_is_legal(input logic [5:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
      default:                              legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_control_output_decode.sv
// control_output_decode: purely combinational decode of the current FSM
// state (plus memReady for the FETCH Mealy terms and the opcode for the
// illegal-opcode flag) into every datapath select and write enable.
// Ports:
//   rst_n_i       reset level; low forces the reset output values
//   state_i       current FSM state
//   opcode_i      IR opcode field
//   mem_ready_i   memory handshake
//   *_o           one output per datapath control (see top-level header)
module control_output_decode
  import multicycle_control_pkg::*;
(
  input  logic       rst_n_i,
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       ior_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       illegal_op_o
);

  // Output decode: everything defaults to 0, each state raises only its own controls.
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    ior_d_o         = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = ALUSRCB_B;
    alu_op_o        = ALUOP_ADD;
    pc_source_o     = PCSRC_ALU;
    illegal_op_o    = 1'b0;
    if (!rst_n_i) begin
      // Reset cycle: no request or write escapes, selects park at fetch values.
      alu_src_b_o = ALUSRCB_FOUR;
    end else begin
      case (state_i)
        STATE_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = ALUSRCB_FOUR;
          // IR and PC load only once the fetch read actually completes.
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        STATE_DECODE: begin
          alu_src_b_o  = ALUSRCB_IMM_SH2;
          illegal_op_o = ~op_is_legal(opcode_i);
        end
        STATE_MEMADR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = ALUSRCB_IMM;
        end
        STATE_MEMRD: begin
          mem_read_o = 1'b1;
          ior_d_o    = 1'b1;
        end
        STATE_MEMWB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
        end
        STATE_MEMWR: begin
          mem_write_o = 1'b1;
          ior_d_o     = 1'b1;
        end
        STATE_EXECUTE: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALUOP_FUNCT;
        end
        STATE_ALUWB: begin
          reg_write_o = 1'b1;
          reg_dst_o   = 1'b1;
        end
        STATE_BRANCH: begin
          alu_src_a_o     = 1'b1;
          alu_op_o        = ALUOP_SUB;
          pc_write_cond_o = 1'b1;
          pc_source_o     = PCSRC_ALUOUT;
        end
        STATE_JUMP: begin
          pc_write_o  = 1'b1;
          pc_source_o = PCSRC_JUMP;
        end
        default: begin
          // Unused encodings keep every control at 0.
          pc_write_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS-subset
// datapath. Holds the state register and next-state logic; outputs are
// decoded combinationally from the state by control_output_decode.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   opcode          IR[31:26], stable from DECODE onward
//   memReady        memory completed the current access this cycle
//   PCWrite .. PCSource   datapath enables and mux selects
//   illegalOp       one-cycle flag in DECODE for unsupported opcodes
//   stateDbg        current state encoding
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPW = 6,
  parameter int SW  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           memReady,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           MemtoReg,
  output logic           RegDst,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUop,
  output logic [1:0]     PCSource,
  output logic           illegalOp,
  output logic [SW-1:0]  stateDbg
);

  state_e state_q;
  state_e state_d;

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= STATE_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; memory states hold until memReady.
  always_comb begin
    state_d = STATE_FETCH;
    case (state_q)
      STATE_FETCH: begin
        if (memReady) state_d = STATE_DECODE;
        else          state_d = STATE_FETCH;
      end
      STATE_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = STATE_MEMADR;
          OP_RTYPE:     state_d = STATE_EXECUTE;
          OP_BEQ:       state_d = STATE_BRANCH;
          OP_J:         state_d = STATE_JUMP;
          default:      state_d = STATE_FETCH;
        endcase
      end
      STATE_MEMADR: begin
        // Opcode is still lw or sw here; anything else is treated as abandoned.
        if (opcode == OP_LW)      state_d = STATE_MEMRD;
        else if (opcode == OP_SW) state_d = STATE_MEMWR;
        else                      state_d = STATE_FETCH;
      end
      STATE_MEMRD: begin
        if (memReady) state_d = STATE_MEMWB;
        else          state_d = STATE_MEMRD;
      end
      STATE_MEMWR: begin
        if (memReady) state_d = STATE_FETCH;
        else          state_d = STATE_MEMWR;
      end
      STATE_EXECUTE: state_d = STATE_ALUWB;
      STATE_MEMWB,
      STATE_ALUWB,
      STATE_BRANCH,
      STATE_JUMP:    state_d = STATE_FETCH;
      default:       state_d = STATE_FETCH;
    endcase
  end

  control_output_decode u_decode (
    .rst_n_i         (rst_n),
    .state_i         (state_q),
    .opcode_i        (opcode),
    .mem_ready_i     (memReady),
    .pc_write_o      (PCWrite),
    .pc_write_cond_o (PCWriteCond),
    .ior_d_o         (IorD),
    .mem_read_o      (MemRead),
    .mem_write_o     (MemWrite),
    .ir_write_o      (IRWrite),
    .mem_to_reg_o    (MemtoReg),
    .reg_dst_o       (RegDst),
    .reg_write_o     (RegWrite),
    .alu_src_a_o     (ALUSrcA),
    .alu_src_b_o     (ALUSrcB),
    .alu_op_o        (ALUop),
    .pc_source_o     (PCSource),
    .illegal_op_o    (illegalOp)
  );

  // stateDbg reads 0 while reset is held, matching the reset output values.
  assign stateDbg = rst_n ? SW'(state_q) : {SW{1'b0}};

endmodule
